// File: rtl/fc_stream_driver.sv
// Stream initiator for a fully connected layer: sends a host-loaded N-word vector over
// valid/ready, then captures M result words into a host-readable buffer.
module fc_stream_driver #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int M     = 6,
    localparam int AW   = (N > 1) ? $clog2(N) : 1,
    localparam int RW   = (M > 1) ? $clog2(M) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_en,
    input  logic [AW-1:0]           load_addr,
    input  logic signed [WIDTH-1:0] load_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic signed [WIDTH-1:0] tx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    input  logic signed [WIDTH-1:0] rx_data,
    input  logic [RW-1:0]           rd_addr,
    output logic signed [WIDTH-1:0] rd_data
);

    typedef enum logic [1:0] {StIdle, StSend, StRecv} state_t;

    state_t                  state;
    logic [AW-1:0]           tx_cnt;
    logic [RW-1:0]           rx_cnt;
    logic [AW-1:0]           tx_next;
    logic signed [WIDTH-1:0] vec [N];
    logic signed [WIDTH-1:0] res [M];
    logic                    load_ok;
    logic                    rd_ok;
    logic                    tx_hs;
    logic                    rx_hs;

    // Address range checks only exist when the depth is not a power of two.
    if (N == (1 << AW)) begin : g_load_full
        assign load_ok = 1'b1;
    end else begin : g_load_part
        assign load_ok = (load_addr < AW'(N));
    end

    if (M == (1 << RW)) begin : g_rd_full
        assign rd_ok = 1'b1;
    end else begin : g_rd_part
        assign rd_ok = (rd_addr < RW'(M));
    end

    assign busy    = (state == StSend) || (state == StRecv);
    assign tx_hs   = (state == StSend) && tx_valid && tx_ready;
    assign rx_hs   = (state == StRecv) && rx_ready && rx_valid;
    assign tx_next = tx_cnt + AW'(1);

    // Buffers are deliberately left out of reset so contents survive an abort.
    always_ff @(posedge clk) begin
        if (load_en && !busy && load_ok) begin
            vec[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_hs) begin
            res[rx_cnt] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            rx_ready <= 1'b0;
            done     <= 1'b0;
            rd_data  <= '0;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
        end else begin
            done    <= 1'b0;
            rd_data <= rd_ok ? res[rd_addr] : '0;
            unique case (state)
                StIdle: begin
                    // The done cycle is still IDLE but must not relaunch a run.
                    if (start && !done) begin
                        state    <= StSend;
                        tx_valid <= 1'b1;
                        tx_data  <= vec[0];
                        tx_cnt   <= '0;
                    end
                end
                StSend: begin
                    if (tx_hs) begin
                        if (tx_cnt == AW'(N - 1)) begin
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            rx_cnt   <= '0;
                            rx_ready <= 1'b1;
                            state    <= StRecv;
                        end else begin
                            tx_cnt  <= tx_next;
                            tx_data <= vec[tx_next];
                        end
                    end
                end
                StRecv: begin
                    if (rx_hs) begin
                        if (rx_cnt == RW'(M - 1)) begin
                            rx_ready <= 1'b0;
                            done     <= 1'b1;
                            state    <= StIdle;
                        end else begin
                            rx_cnt <= rx_cnt + RW'(1);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_stream_driver.sv
// Randomised bench for fc_stream_driver with a vector/result model and a toy layer model.
module tb_fc_stream_driver;

    localparam int WIDTH = 16;
    localparam int N     = 8;
    localparam int M     = 6;
    localparam int AW    = $clog2(N);
    localparam int RW    = $clog2(M);

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    load_en;
    logic [AW-1:0]           load_addr;
    logic signed [WIDTH-1:0] load_data;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    tx_valid;
    logic                    tx_ready;
    logic signed [WIDTH-1:0] tx_data;
    logic                    rx_valid;
    logic                    rx_ready;
    logic signed [WIDTH-1:0] rx_data;
    logic [RW-1:0]           rd_addr;
    logic signed [WIDTH-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    logic signed [WIDTH-1:0] vec_m [N];
    logic signed [WIDTH-1:0] res_m [M];
    logic signed [WIDTH-1:0] sent_q [$];

    always #5 clk = ~clk;

    fc_stream_driver #(.WIDTH(WIDTH), .N(N), .M(M)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .busy(busy), .done(done),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic signed [WIDTH-1:0] v);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = v;
        vec_m[addr] = v;
        step;
        load_en = 1'b0;
    endtask

    task automatic load_random;
        for (int i = 0; i < N; i++) load_word(i, WIDTH'($urandom));
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    // Drives tx_ready and expects the vector in order; hold_idx forces a 3-cycle stall.
    task automatic send_phase(input int stall_pct, input int hold_idx, input int abort_after,
                              input bit poke, output int cycles);
        int sent = 0;
        int held = 0;
        cycles = 0;
        sent_q.delete();
        while (sent < N && cycles < 400) begin
            if (sent == hold_idx && held < 3) begin
                tx_ready = 1'b0;
                held++;
            end else begin
                tx_ready = ($urandom_range(99) >= stall_pct);
            end
            if (poke) begin
                load_en   = 1'b1;
                load_addr = '0;
                load_data = WIDTH'($urandom);
                start     = 1'b1;
            end
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== vec_m[sent]) begin
                errors++;
                $display("FAIL tx_word[%0d] valid=%0b data=%0d required valid=1 data=%0d",
                         sent, tx_valid, tx_data, vec_m[sent]);
            end
            if (tx_ready) begin
                sent_q.push_back(tx_data);
                sent++;
            end
            step;
            cycles++;
            if (sent == abort_after) begin
                tx_ready = 1'b0;
                return;
            end
        end
        tx_ready = 1'b0;
        load_en  = 1'b0;
        start    = 1'b0;
        checks++;
        if (sent != N || tx_valid !== 1'b0 || tx_data !== '0 || rx_ready !== 1'b1 ||
            busy !== 1'b1) begin
            errors++;
            $display("FAIL send_end sent=%0d valid=%0b data=%0d rx_ready=%0b busy=%0b required %0d,0,0,1,1",
                     sent, tx_valid, tx_data, rx_ready, busy, N);
        end
    endtask

    task automatic recv_phase(input logic signed [WIDTH-1:0] words [M], input int gap_pct,
                              input bit poke);
        int k = 0;
        int cyc = 0;
        while (k < M && cyc < 400) begin
            rx_valid = ($urandom_range(99) >= gap_pct);
            rx_data  = rx_valid ? words[k] : WIDTH'($urandom);
            if (poke) begin
                load_en   = 1'b1;
                load_addr = '0;
                load_data = WIDTH'($urandom);
                start     = 1'b1;
            end
            checks++;
            if (rx_ready !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL recv[%0d] rx_ready=%0b done=%0b required 1,0", k, rx_ready, done);
            end
            if (rx_valid) k++;
            step;
            cyc++;
        end
        rx_valid = 1'b0;
        load_en  = 1'b0;
        start    = 1'b0;
        for (int i = 0; i < M; i++) res_m[i] = words[i];
        checks++;
        if (k != M || done !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL recv_end k=%0d done=%0b busy=%0b rx_ready=%0b required %0d,1,0,0",
                     k, done, busy, rx_ready, M);
        end
        // Junk on rx while not ready must not land in the buffer; start in done cycle ignored.
        rx_valid = 1'b1;
        rx_data  = WIDTH'($urandom);
        start    = 1'b1;
        step;
        start    = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%0b busy=%0b required 0,0", done, busy);
        end
        step;
        rx_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL no_rerun busy=%0b required 0", busy);
        end
    endtask

    task automatic check_results;
        for (int i = 0; i < M; i++) begin
            rd_addr = RW'(i);
            step;
            checks++;
            if (rd_data !== res_m[i]) begin
                errors++;
                $display("FAIL res[%0d] got %0d required %0d", i, rd_data, res_m[i]);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; rd_addr = '0;
        step;
        step;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== '0 || rx_ready !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_state valid=%0b data=%0d rx_ready=%0b busy=%0b done=%0b rd=%0d required all 0",
                     tx_valid, tx_data, rx_ready, busy, done, rd_data);
        end
        reset = 1'b0;
        step;
    endtask

    task automatic test_basic;
        int cyc;
        logic signed [WIDTH-1:0] words [M];
        words = '{16'sd10, -16'sd20, 16'sd30, 16'sd0, 16'sd32767, 16'sh8000};
        for (int i = 0; i < N; i++) load_word(i, WIDTH'(i + 1));
        load_word(3, 16'sd99);
        load_word(3, 16'sd4);
        pulse_start;
        send_phase(0, -1, -1, 1'b0, cyc);
        checks++;
        if (cyc != N) begin
            errors++;
            $display("FAIL back_to_back cycles=%0d required %0d", cyc, N);
        end
        recv_phase(words, 50, 1'b0);
        check_results;
        rd_addr = RW'(4);
        step;
        checks++;
        if (rd_data !== 16'sd32767) begin
            errors++;
            $display("FAIL rd_addr4 got %0d required 32767", rd_data);
        end
        rd_addr = RW'(6);
        step;
        checks++;
        if (rd_data !== '0) begin
            errors++;
            $display("FAIL rd_out_of_range got %0d required 0", rd_data);
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        logic signed [WIDTH-1:0] words [M];
        for (int i = 0; i < M; i++) words[i] = WIDTH'($urandom);
        pulse_start;
        send_phase(0, 2, -1, 1'b0, cyc);
        checks++;
        if (cyc != N + 3) begin
            errors++;
            $display("FAIL backpressure cycles=%0d required %0d", cyc, N + 3);
        end
        recv_phase(words, 0, 1'b0);
        check_results;
    endtask

    task automatic test_random_runs;
        int cyc;
        logic signed [WIDTH-1:0] words [M];
        for (int r = 0; r < 4; r++) begin
            load_random;
            for (int i = 0; i < M; i++) words[i] = WIDTH'($urandom);
            pulse_start;
            send_phase(int'($urandom_range(70)), -1, -1, 1'b0, cyc);
            recv_phase(words, int'($urandom_range(70)), 1'b0);
            check_results;
        end
    endtask

    task automatic test_ignored_controls;
        int cyc;
        logic signed [WIDTH-1:0] words [M];
        load_random;
        for (int i = 0; i < M; i++) words[i] = WIDTH'($urandom);
        pulse_start;
        send_phase(30, -1, -1, 1'b1, cyc);
        recv_phase(words, 30, 1'b1);
        check_results;
        pulse_start;
        send_phase(0, -1, -1, 1'b0, cyc);
        recv_phase(words, 0, 1'b0);
    endtask

    task automatic test_async_reset;
        int cyc;
        logic signed [WIDTH-1:0] words [M];
        load_random;
        for (int i = 0; i < M; i++) words[i] = WIDTH'($urandom);
        pulse_start;
        send_phase(0, -1, 4, 1'b0, cyc);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== '0 || rx_ready !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset valid=%0b data=%0d rx_ready=%0b busy=%0b done=%0b required all 0",
                     tx_valid, tx_data, rx_ready, busy, done);
        end
        step;
        reset = 1'b0;
        step;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset busy=%0b valid=%0b required 0,0", busy, tx_valid);
        end
        pulse_start;
        send_phase(20, -1, -1, 1'b0, cyc);
        recv_phase(words, 20, 1'b0);
        check_results;
    endtask

    task automatic test_end_to_end;
        int cyc;
        int acc;
        int w [M][N];
        int b [M];
        logic signed [WIDTH-1:0] golden [M];
        logic signed [WIDTH-1:0] words [M];
        for (int i = 0; i < N; i++) load_word(i, WIDTH'(int'($urandom_range(200)) - 100));
        for (int j = 0; j < M; j++) begin
            b[j] = int'($urandom_range(200)) - 100;
            for (int i = 0; i < N; i++) w[j][i] = int'($urandom_range(16)) - 8;
        end
        for (int j = 0; j < M; j++) begin
            acc = b[j];
            for (int i = 0; i < N; i++) acc += w[j][i] * int'(vec_m[i]);
            golden[j] = WIDTH'((acc < 0) ? 0 : acc);
        end
        pulse_start;
        send_phase(25, -1, -1, 1'b0, cyc);
        // Layer model: computes from what actually crossed the tx stream.
        for (int j = 0; j < M; j++) begin
            acc = b[j];
            for (int i = 0; i < N && i < sent_q.size(); i++) acc += w[j][i] * int'(sent_q[i]);
            words[j] = WIDTH'((acc < 0) ? 0 : acc);
        end
        recv_phase(words, 25, 1'b0);
        for (int j = 0; j < M; j++) res_m[j] = golden[j];
        check_results;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_ignored_controls;
        test_async_reset;
        test_random_runs;
        test_end_to_end;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
